bsg_fifo_tracker_multi: RTL and testbench
=========================================

Name: bsg_fifo_tracker_multi

Overview:
- Bookkeeping stage for a circular-buffer FIFO whose storage is a separate 1R1W memory of els_p slots.
- Accepts up to max_enq_p writes and up to max_deq_p reads per cycle.
- Produces registered write and read addresses, a look-ahead read address, and occupancy, free count, full and empty status.
- Sits directly downstream of the add-count logic and upstream of the storage array; the storage array consumes its pointers as write and read addresses.

Parameters:
- els_p, 8, number of storage slots (>=1, need not be a power of two)
- max_enq_p, 1, maximum enqueues per cycle (1..els_p)
- max_deq_p, 1, maximum dequeues per cycle (1..els_p)
- ptr_width_lp, local, `BSG_SAFE_CLOG2(els_p)
- cnt_width_lp, local, $clog2(els_p+1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n_i  in  1  asynchronous active-low reset
- enq_cnt_i  in  $clog2(max_enq_p+1)  entries written this cycle
- deq_cnt_i  in  $clog2(max_deq_p+1)  entries read this cycle
- wptr_r_o  out  ptr_width_lp  slot of next write (base address this cycle)
- rptr_r_o  out  ptr_width_lp  slot of oldest entry
- rptr_n_o  out  ptr_width_lp  next-cycle rptr (for synchronous-read RAM)
- occ_r_o  out  cnt_width_lp  entries held
- free_r_o  out  cnt_width_lp  els_p - occ_r_o
- full_o  out  1  occ_r_o == els_p
- empty_o  out  1  occ_r_o == 0
- err_r_o  out  1  sticky illegal-request flag

Behaviour:
- Reset: asynchronous, active-low. While reset_n_i=0, all state is held at reset values:
  - wptr=0, rptr=0, occ=0, free=els_p, err=0
  - empty_o=1, full_o=0
  - rptr_n_o=0
- Deassertion takes effect at the next clock edge.
- Per cycle, with enq = enq_cnt_i and deq = deq_cnt_i:
  - wptr_n = (wptr + enq) mod els_p
  - rptr_n = (rptr + deq) mod els_p
  - occ_n = occ + enq - deq
  - free_n = els_p - occ_n
- Width rules:
  - Sums are computed one bit wider than the operand.
  - Non-power-of-two wrap uses the parallel wrapped/unwrapped compute, selected on the sign of (ptr + add - els_p).
  - Power-of-two sizes use truncation only.
  - els_p=1: both pointers are constant 0.
- Latency: pointer and count updates are visible one cycle after the request. rptr_n_o is combinational from deq_cnt_i.
- Simultaneous enqueue and dequeue: permitted in the same cycle, including when full (dequeue frees slots that same-cycle enqueue may use only if enq <= free + deq). Legal limits:
  - enq <= free + deq
  - deq <= occ
- A dequeue never sees same-cycle enqueued data: deq <= occ_r_o, not occ + enq.
- Wrap-around: a pointer equal to els_p-1 plus add k lands on slot k-1.
- full_o and empty_o are decoded from registered occ, so there is no combinational path from the inputs.
- err_r_o sets on any cycle violating the legal limits and stays set until reset.

Optional Feature:
- Macro: BSG_FIFO_TRACKER_CLAMP_EN.
- Defined:
  - deq is clamped to occ before use.
  - enq is clamped to free + clamped deq before use.
  - Pointers and occupancy always remain consistent; err_r_o still records the violation.
- Undefined:
  - Raw counts are used and err_r_o is still computed.
  - Post-violation pointer and occupancy state is unspecified.
  - A simulation-only assertion fires on violation.

Decomposition:
- Shared package bsg_fifo_tracker_pkg holds:
  - the count width function
  - the error-cause enum (enq_overflow, deq_underflow)
- Sub-module bsg_circular_ptr_arn: circular pointer with async active-low reset and look-ahead output; instantiated twice (write and read).
- Occupancy and error logic live in the top module.

Test Plan:
- Reset: els_p=5, max 3/3, reset_n_i pulsed low mid-stream with occ=3 -> all outputs immediately return to reset values (wptr=0, rptr=0, occ=0, free=5, empty=1, full=0, err=0), with no clock edge required.
- Wrap: els_p=5, enq 3, 3 (with deq 2 in the second cycle) -> wptr 0->3->1; occ 0->3->4.
- Full boundary: els_p=5, fill to occ=5, then enq=2 with deq=2 -> full stays 1, wptr and rptr each advance by 2 mod 5, err=0.
- Empty boundary: occ=1, deq=1 with enq=1 -> occ stays 1, empty_o never asserts, rptr_n_o equals rptr+1 combinationally.
- Violation: occ=0, deq=1 -> err_r_o=1 next cycle and stays 1 after legal traffic; with BSG_FIFO_TRACKER_CLAMP_EN, occ stays 0 and rptr is unchanged.
- Power of two: els_p=8, max 1/1, 20 random single ops checked against a reference queue model -> pointers and occupancy match every cycle.

Source files
------------

// File: rtl/bsg_fifo_tracker_pkg.sv
// rtl/bsg_fifo_tracker_pkg.sv - shared widths, helpers and error causes for the FIFO tracker
//
// Purpose: width helper functions and the error-cause encoding shared by
//          bsg_fifo_tracker_multi and bsg_circular_ptr_arn.
// Ports:   none (package).
package bsg_fifo_tracker_pkg;

  // Pointer width that never collapses to zero bits (a 1-slot buffer still gets a 1-bit pointer).
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // Width able to hold every count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Bit positions inside the per-cycle error vector.
  typedef enum logic {
    ERR_ENQ_OVERFLOW  = 1'b0,
    ERR_DEQ_UNDERFLOW = 1'b1
  } err_cause_e;

endpackage

// File: rtl/bsg_circular_ptr_arn.sv
// rtl/bsg_circular_ptr_arn.sv - circular slot pointer with async active-low reset and look-ahead
//
// Purpose: holds a pointer into a ring of slots_p entries and advances it by
//          add_i each cycle, wrapping modulo slots_p.
// Ports:
//   clk        in   clock
//   reset_n_i  in   asynchronous active-low reset
//   add_i      in   slots to advance this cycle (0..max_add_p)
//   ptr_r_o    out  registered pointer
//   ptr_n_o    out  next-cycle pointer, combinational from add_i (0 while in reset)
module bsg_circular_ptr_arn
  import bsg_fifo_tracker_pkg::*;
#(
  parameter  int slots_p      = 8,
  parameter  int max_add_p    = 1,
  localparam int ptr_width_lp = safe_clog2(slots_p),
  localparam int add_width_lp = cnt_width(max_add_p)
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic [add_width_lp-1:0] add_i,
  output logic [ptr_width_lp-1:0] ptr_r_o,
  output logic [ptr_width_lp-1:0] ptr_n_o
);

  localparam int sum_width_lp = ptr_width_lp + 1;

  logic [ptr_width_lp-1:0] ptr_q, ptr_d;

  if (slots_p == 1) begin : g_one
    // A single slot: the pointer can only ever be zero.
    logic unused_add;
    assign unused_add = ^add_i;
    assign ptr_d      = '0;
  end else if (is_pow2(slots_p)) begin : g_pow2
    // Power-of-two ring: dropping the carry is the modulo.
    assign ptr_d = ptr_q + ptr_width_lp'(add_i);
  end else begin : g_npow2
    // ptr + add < 2*slots_p, so at most one subtraction of slots_p is needed.
    // Compute both candidates and pick on the sign of (sum - slots_p).
    logic [sum_width_lp-1:0] sum_w;
    logic [sum_width_lp:0]   diff_w;
    assign sum_w  = {1'b0, ptr_q} + sum_width_lp'(add_i);
    assign diff_w = {1'b0, sum_w} - (sum_width_lp + 1)'(slots_p);
    assign ptr_d  = diff_w[sum_width_lp] ? ptr_width_lp'(sum_w) : ptr_width_lp'(diff_w);
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_r_o = ptr_q;
  assign ptr_n_o = reset_n_i ? ptr_d : '0;

endmodule

// File: rtl/bsg_fifo_tracker_multi.sv
// rtl/bsg_fifo_tracker_multi.sv - multi-enqueue/multi-dequeue circular FIFO bookkeeping
//
// Purpose: tracks write/read slots, occupancy and free count for a 1R1W
//          circular buffer of els_p slots accepting up to max_enq_p writes and
//          max_deq_p reads per cycle. Illegal requests set a sticky error.
// Build option: BSG_FIFO_TRACKER_CLAMP_EN clamps counts to legal values so state
//          stays consistent after a violation; otherwise raw counts are used and
//          a simulation-only assertion reports the violation.
// Ports:
//   clk        in   clock
//   reset_n_i  in   asynchronous active-low reset
//   enq_cnt_i  in   entries written this cycle
//   deq_cnt_i  in   entries read this cycle
//   wptr_r_o   out  slot of next write
//   rptr_r_o   out  slot of oldest entry
//   rptr_n_o   out  next-cycle read slot (combinational, for sync-read RAM)
//   occ_r_o    out  entries held
//   free_r_o   out  els_p - occ_r_o
//   full_o     out  occupancy equals els_p
//   empty_o    out  occupancy is zero
//   err_r_o    out  sticky illegal-request flag
module bsg_fifo_tracker_multi
  import bsg_fifo_tracker_pkg::*;
#(
  parameter  int els_p        = 8,
  parameter  int max_enq_p    = 1,
  parameter  int max_deq_p    = 1,
  localparam int ptr_width_lp = safe_clog2(els_p),
  localparam int cnt_width_lp = cnt_width(els_p),
  localparam int enq_width_lp = cnt_width(max_enq_p),
  localparam int deq_width_lp = cnt_width(max_deq_p)
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic [enq_width_lp-1:0] enq_cnt_i,
  input  logic [deq_width_lp-1:0] deq_cnt_i,
  output logic [ptr_width_lp-1:0] wptr_r_o,
  output logic [ptr_width_lp-1:0] rptr_r_o,
  output logic [ptr_width_lp-1:0] rptr_n_o,
  output logic [cnt_width_lp-1:0] occ_r_o,
  output logic [cnt_width_lp-1:0] free_r_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    err_r_o
);

  // Two spare bits: free + deq reaches 2*els_p, and occ + enq - deq must not wrap.
  localparam int aw_lp = cnt_width_lp + 2;

  logic [cnt_width_lp-1:0] occ_q, occ_d, free_q, free_d;
  logic                    err_q, err_d;
  logic [aw_lp-1:0]        occ_w, free_w, enq_w, deq_w, enq_use, deq_use, occ_sum;
  logic [1:0]              err_vec;

  always_comb begin
    occ_w   = aw_lp'(occ_q);
    free_w  = aw_lp'(free_q);
    enq_w   = aw_lp'(enq_cnt_i);
    deq_w   = aw_lp'(deq_cnt_i);

    // Reads only see registered occupancy; same-cycle writes are not readable yet.
    err_vec = '0;
    err_vec[ERR_DEQ_UNDERFLOW] = (deq_w > occ_w);
    err_vec[ERR_ENQ_OVERFLOW]  = (enq_w > free_w + deq_w);

`ifdef BSG_FIFO_TRACKER_CLAMP_EN
    deq_use = (deq_w > occ_w) ? occ_w : deq_w;
    enq_use = (enq_w > free_w + deq_use) ? (free_w + deq_use) : enq_w;
`else
    deq_use = deq_w;
    enq_use = enq_w;
`endif

    occ_sum = occ_w + enq_use - deq_use;
    occ_d   = cnt_width_lp'(occ_sum);
    free_d  = cnt_width_lp'(els_p) - occ_d;
    err_d   = err_q | (|err_vec);
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ_q  <= '0;
      free_q <= cnt_width_lp'(els_p);
      err_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      free_q <= free_d;
      err_q  <= err_d;
    end
  end

  logic [ptr_width_lp-1:0] wptr_n_unused;

  bsg_circular_ptr_arn #(
    .slots_p   (els_p),
    .max_add_p (max_enq_p)
  ) u_wptr (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .add_i     (enq_width_lp'(enq_use)),
    .ptr_r_o   (wptr_r_o),
    .ptr_n_o   (wptr_n_unused)
  );

  bsg_circular_ptr_arn #(
    .slots_p   (els_p),
    .max_add_p (max_deq_p)
  ) u_rptr (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .add_i     (deq_width_lp'(deq_use)),
    .ptr_r_o   (rptr_r_o),
    .ptr_n_o   (rptr_n_o)
  );

  assign occ_r_o  = occ_q;
  assign free_r_o = free_q;
  assign full_o   = (occ_q == cnt_width_lp'(els_p));
  assign empty_o  = (occ_q == '0);
  assign err_r_o  = err_q;

`ifndef BSG_FIFO_TRACKER_CLAMP_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n_i) begin
      assert (err_vec == 2'b00)
        else $warning("bsg_fifo_tracker_multi: illegal enq/deq count request");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_bsg_fifo_tracker_multi.sv
// tb/tb_bsg_fifo_tracker_multi.sv - scoreboard bench for bsg_fifo_tracker_multi
module tb_bsg_fifo_tracker_multi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT 0: els_p=5, max 3/3.  DUT 1: els_p=8, max 1/1.
  logic [1:0] enq_a, deq_a;
  logic [2:0] wptr_a, rptr_a, rptr_n_a, occ_a, free_a;
  logic       full_a, empty_a, err_a;
  logic [0:0] enq_b, deq_b;
  logic [2:0] wptr_b, rptr_b, rptr_n_b;
  logic [3:0] occ_b, free_b;
  logic       full_b, empty_b, err_b;

  bsg_fifo_tracker_multi #(.els_p(5), .max_enq_p(3), .max_deq_p(3)) dut_a (
    .clk(clk), .reset_n_i(rst_n), .enq_cnt_i(enq_a), .deq_cnt_i(deq_a),
    .wptr_r_o(wptr_a), .rptr_r_o(rptr_a), .rptr_n_o(rptr_n_a), .occ_r_o(occ_a),
    .free_r_o(free_a), .full_o(full_a), .empty_o(empty_a), .err_r_o(err_a)
  );

  bsg_fifo_tracker_multi #(.els_p(8), .max_enq_p(1), .max_deq_p(1)) dut_b (
    .clk(clk), .reset_n_i(rst_n), .enq_cnt_i(enq_b), .deq_cnt_i(deq_b),
    .wptr_r_o(wptr_b), .rptr_r_o(rptr_b), .rptr_n_o(rptr_n_b), .occ_r_o(occ_b),
    .free_r_o(free_b), .full_o(full_b), .empty_o(empty_b), .err_r_o(err_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: lifetime totals of accepted writes/reads per DUT.
  int els[2]   = '{5, 8};
  int mx[2]    = '{3, 1};
  int tot_e[2] = '{0, 0};
  int tot_d[2] = '{0, 0};
  int merr[2]  = '{0, 0};
  bit mvalid[2] = '{1'b1, 1'b1};

  typedef struct {
    int cyc;
    int d;
    int wptr;
    int rptr;
    int occ;
    int err;
    bit valid;
  } exp_t;
  exp_t sb[$];

  // Monitor: compares registered outputs against the entry due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int w, r, o, f, fu, em, er;
      e = sb.pop_front();
      chk("sb_cycle", cyc, e.cyc);
      if (e.d == 0) begin
        w = int'(wptr_a); r = int'(rptr_a); o = int'(occ_a); f = int'(free_a);
        fu = int'(full_a); em = int'(empty_a); er = int'(err_a);
      end else begin
        w = int'(wptr_b); r = int'(rptr_b); o = int'(occ_b); f = int'(free_b);
        fu = int'(full_b); em = int'(empty_b); er = int'(err_b);
      end
      if (e.valid) begin
        chk($sformatf("wptr[%0d]", e.d), w, e.wptr);
        chk($sformatf("rptr[%0d]", e.d), r, e.rptr);
        chk($sformatf("occ[%0d]", e.d), o, e.occ);
        chk($sformatf("free[%0d]", e.d), f, els[e.d] - e.occ);
        chk($sformatf("full[%0d]", e.d), fu, (e.occ == els[e.d]) ? 1 : 0);
        chk($sformatf("empty[%0d]", e.d), em, (e.occ == 0) ? 1 : 0);
      end
      chk($sformatf("err[%0d]", e.d), er, e.err);
    end
  end

  // One request cycle on DUT d; called and returns at a falling edge.
  task automatic step(input int d, input int enq, input int deq);
    int occ, fr, de, ee;
    bit bad;
    exp_t e;
    occ = tot_e[d] - tot_d[d];
    fr  = els[d] - occ;
    bad = (deq > occ) || (enq > fr + deq);
`ifdef BSG_FIFO_TRACKER_CLAMP_EN
    de = (deq > occ) ? occ : deq;
    ee = (enq > fr + de) ? fr + de : enq;
`else
    de = deq;
    ee = enq;
`endif
    enq_a = '0; deq_a = '0; enq_b = '0; deq_b = '0;
    if (d == 0) begin enq_a = 2'(enq); deq_a = 2'(deq); end
    else        begin enq_b = 1'(enq); deq_b = 1'(deq); end
    #1;
    if (mvalid[d])
      chk($sformatf("rptr_n[%0d]", d), (d == 0) ? int'(rptr_n_a) : int'(rptr_n_b),
          (tot_d[d] + de) % els[d]);
`ifndef BSG_FIFO_TRACKER_CLAMP_EN
    if (bad) mvalid[d] = 1'b0;
`endif
    if (bad) merr[d] = 1;
    tot_e[d] += ee;
    tot_d[d] += de;
    e.cyc = cyc + 1; e.d = d;
    e.wptr = tot_e[d] % els[d]; e.rptr = tot_d[d] % els[d];
    e.occ = tot_e[d] - tot_d[d]; e.err = merr[d]; e.valid = mvalid[d];
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_step(input int d);
    int occ, fr, deq, enq, hi;
    occ = tot_e[d] - tot_d[d];
    fr  = els[d] - occ;
    hi  = (mx[d] < occ) ? mx[d] : occ;
    deq = int'($urandom_range(hi, 0));
    hi  = (mx[d] < fr + deq) ? mx[d] : fr + deq;
    enq = int'($urandom_range(hi, 0));
    step(d, enq, deq);
  endtask

  task automatic check_reset_vals();
    chk("rst_wptr_a", int'(wptr_a), 0);   chk("rst_rptr_a", int'(rptr_a), 0);
    chk("rst_rptrn_a", int'(rptr_n_a), 0); chk("rst_occ_a", int'(occ_a), 0);
    chk("rst_free_a", int'(free_a), 5);   chk("rst_empty_a", int'(empty_a), 1);
    chk("rst_full_a", int'(full_a), 0);   chk("rst_err_a", int'(err_a), 0);
    chk("rst_wptr_b", int'(wptr_b), 0);   chk("rst_occ_b", int'(occ_b), 0);
    chk("rst_free_b", int'(free_b), 8);   chk("rst_err_b", int'(err_b), 0);
  endtask

  // Asynchronous reset pulse started between clock edges; values checked before any edge.
  task automatic do_reset();
    enq_a = '0; deq_a = '0; enq_b = '0; deq_b = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tot_e[i] = 0; tot_d[i] = 0; merr[i] = 0; mvalid[i] = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enq_a = '0; deq_a = '0; enq_b = '0; deq_b = '0;
    @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Wrap, then full boundary, then near-empty boundary on DUT 0.
    step(0, 3, 0);
    step(0, 3, 2);
    step(0, 1, 0);
    step(0, 2, 2);
    step(0, 0, 3);
    step(0, 0, 1);
    step(0, 1, 1);
    // Mid-stream reset with three entries held.
    step(0, 2, 0);
    do_reset();

    // Underflow from empty; the error must survive later legal traffic.
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    do_reset();

    for (int i = 0; i < 30; i++) rand_step(0);
    for (int i = 0; i < 20; i++) rand_step(1);

    enq_a = '0; deq_a = '0; enq_b = '0; deq_b = '0;
    repeat (3) @(negedge clk);
    chk("sb_final_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
